// File: rtl/sram_like_resp_if.sv
// Request/response signal bundle of the sram-like req/addr_ok/data_ok protocol.
// The master issues requests; the slave accepts them and returns in-order responses.
interface sram_like_resp_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata, err
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata, err
  );
endinterface

// File: rtl/sram_like_resp.sv
// Responder end of the sram-like bus backed by a word-addressed RAM.
// Requests act on the RAM when accepted; responses return in order after LATENCY cycles.
module sram_like_resp #(
  parameter int MEM_AW  = 12,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  sram_like_resp_if.slave              bus,
  input  logic                         stall_i,
  input  logic                         resp_stall_i,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding_o
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] s;
    s = 4'b0000;
    case (size)
      2'd0:    s = 4'b0001 << lo;
      2'd1:    s = lo[1] ? 4'b1100 : 4'b0011;
      2'd2:    s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lo);
    return (size == 2'd3) || ((size == 2'd1) && lo[0]) || ((size == 2'd2) && (lo != 2'd0));
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [31:0]       mem [0:(1 << MEM_AW) - 1];
  logic [31:0]       q_data [DEPTH];
  logic              q_err  [DEPTH];
  logic [CNT_W-1:0]  q_cnt  [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [OCC_W-1:0]  occ;

  logic [MEM_AW-1:0] widx;
  logic [3:0]        strb;
  logic              illegal;
  logic              accept;
  logic              pop;
  logic              head_ready;

  // Address bits above the RAM window alias onto the same words.
  generate
    if (MEM_AW + 2 < 32) begin : g_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.addr[31:MEM_AW+2];
    end
  endgenerate

  assign widx    = bus.addr[MEM_AW+1:2];
  assign strb    = byte_strobe(bus.size, bus.addr[1:0]);
  assign illegal = is_illegal(bus.size, bus.addr[1:0]);

  // A pop in the same cycle never frees a slot: addr_ok looks at occupancy only.
  assign bus.addr_ok = rst_n & ~stall_i & (occ < OCC_W'(DEPTH));
  assign accept      = bus.req & bus.addr_ok;

  assign head_ready  = (occ != '0) && (q_cnt[rptr] == '0);
  assign bus.data_ok = head_ready & ~resp_stall_i;
  assign pop         = bus.data_ok;
  assign bus.rdata   = bus.data_ok ? q_data[rptr] : 32'd0;
  assign bus.err     = bus.data_ok & q_err[rptr];

  assign outstanding_o = occ;

  // RAM: write happens at the accept edge so later reads observe it.
  always_ff @(posedge clk) begin
    if (accept && bus.wr && !illegal) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mem[widx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  // Response payload captured at acceptance; writes and illegal requests return zero.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_data[wptr] <= (bus.wr || illegal) ? 32'd0 : mem[widx];
      q_err[wptr]  <= illegal;
    end
  end

  // Per-entry latency countdown; entries wait at zero until popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (accept && (wptr == PTR_W'(i))) begin
          q_cnt[i] <= CNT_W'(LATENCY - 1);
        end else if (q_cnt[i] != '0) begin
          q_cnt[i] <= q_cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (accept) wptr <= next_ptr(wptr);
      if (pop)    rptr <= next_ptr(rptr);
      if (accept && !pop) begin
        occ <= occ + OCC_W'(1);
      end else if (!accept && pop) begin
        occ <= occ - OCC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sram_like_resp.sv
// Randomized and directed bench for sram_like_resp against a transaction-level model.
module tb_sram_like_resp;

  localparam int MEM_AW  = 12;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 4;

  typedef struct {
    logic [31:0] data;
    bit          err;
    bit          rd;
    bit          known;
    int          due;
  } ent_t;

  logic clk;
  logic rst_n;
  logic stall_i;
  logic resp_stall_i;
  logic [$clog2(DEPTH+1)-1:0] outstanding_o;

  sram_like_resp_if bus();

  sram_like_resp #(.MEM_AW(MEM_AW), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .stall_i       (stall_i),
    .resp_stall_i  (resp_stall_i),
    .outstanding_o (outstanding_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk;
  int          n_fail;
  int          cyc;
  int          n_dok;
  bit          last_acc;
  logic [31:0] last_rd;
  ent_t        mq[$];
  logic [31:0] mm[int];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_accept();
    ent_t        e;
    int          idx;
    logic [1:0]  lo;
    logic [1:0]  sz;
    logic [31:0] w;
    bit          bad;
    idx = int'(bus.addr[MEM_AW+1:2]);
    lo  = bus.addr[1:0];
    sz  = bus.size;
    bad = (sz == 2'd3) || (sz == 2'd1 && lo[0]) || (sz == 2'd2 && lo != 2'd0);
    e.due = cyc + LATENCY;
    e.err = bad;
    e.rd = !bus.wr;
    e.data = 32'd0;
    e.known = 1'b1;
    if (!bad) begin
      if (bus.wr) begin
        if (sz == 2'd2) begin
          mm[idx] = bus.wdata;
        end else if (mm.exists(idx)) begin
          w = mm[idx];
          for (int b = 0; b < 4; b++) begin
            if ((sz == 2'd0) ? (b == int'(lo)) : ((b / 2) == int'(lo[1])))
              w[8*b +: 8] = bus.wdata[8*b +: 8];
          end
          mm[idx] = w;
        end
      end else if (mm.exists(idx)) begin
        e.data = mm[idx];
      end else begin
        e.known = 1'b0;
      end
    end
    mq.push_back(e);
  endtask

  // One clock cycle: check outputs against the model mid-cycle, then advance the model.
  task automatic tick();
    ent_t h;
    bit   ea;
    bit   ed;
    @(negedge clk);
    ea = rst_n && !stall_i && (mq.size() < DEPTH);
    ed = 1'b0;
    if (rst_n && !resp_stall_i && mq.size() != 0) begin
      if (cyc >= mq[0].due) ed = 1'b1;
    end
    check("addr_ok", 32'(bus.addr_ok), 32'(ea));
    check("data_ok", 32'(bus.data_ok), 32'(ed));
    check("outstanding", 32'(outstanding_o), 32'(mq.size()));
    if (ed) begin
      h = mq.pop_front();
      check("err", 32'(bus.err), 32'(h.err));
      if (h.err) check("err_rdata", bus.rdata, 32'd0);
      else if (h.rd && h.known) check("rdata", bus.rdata, h.data);
      if (h.rd && !h.err) last_rd = bus.rdata;
      n_dok++;
    end else begin
      check("rdata_idle", bus.rdata, 32'd0);
      check("err_idle", 32'(bus.err), 32'd0);
    end
    last_acc = bus.req && ea;
    if (last_acc) model_accept();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.req = 1'b0;
    repeat (n) tick();
  endtask

  task automatic issue(input bit w, input bit [1:0] s, input bit [31:0] a, input bit [31:0] d);
    bus.req   = 1'b1;
    bus.wr    = w;
    bus.size  = s;
    bus.addr  = a;
    bus.wdata = d;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (last_acc) break;
    end
    check("accepted", 32'(last_acc), 32'd1);
    bus.req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr_ok"}, 32'(bus.addr_ok), 32'd0);
    check({tag, "_data_ok"}, 32'(bus.data_ok), 32'd0);
    check({tag, "_rdata"}, bus.rdata, 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
    check({tag, "_occ"}, 32'(outstanding_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          hold;
    int          base;
    int          r;
    n_chk = 0; n_fail = 0; cyc = 0; n_dok = 0; last_acc = 1'b0; last_rd = 32'd0;
    rst_n = 1'b0; stall_i = 1'b0; resp_stall_i = 1'b0;
    bus.req = 1'b0; bus.wr = 1'b0; bus.size = 2'd0; bus.addr = 32'd0; bus.wdata = 32'd0;
    #2;
    check_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Word write then read-back
    issue(1'b1, 2'd2, 32'h100, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 32'h100, 32'd0);
    idle(4);
    check("t1_rdata", last_rd, 32'hDEADBEEF);

    // Byte and halfword merges
    issue(1'b1, 2'd2, 32'h100, 32'h11223344);
    issue(1'b1, 2'd0, 32'h101, 32'h0000AA00);
    issue(1'b0, 2'd2, 32'h100, 32'd0);
    idle(4);
    check("t2_byte", last_rd, 32'h1122AA44);
    issue(1'b1, 2'd1, 32'h102, 32'hBEEF0000);
    issue(1'b0, 2'd2, 32'h100, 32'd0);
    idle(4);
    check("t2_half", last_rd, 32'hBEEFAA44);

    // Fill the queue with responses held back
    for (int i = 0; i < 6; i++) issue(1'b1, 2'd2, 32'h104 + 4 * i, 32'hA0A0_0000 + i);
    idle(4);
    base = n_dok;
    resp_stall_i = 1'b1;
    for (int i = 0; i < 4; i++) issue(1'b0, 2'd2, 32'h104 + 4 * i, 32'd0);
    bus.req = 1'b1; bus.wr = 1'b0; bus.size = 2'd2; bus.addr = 32'h114;
    repeat (3) tick();
    check("t3_full_occ", 32'(outstanding_o), 32'd4);
    check("t3_full_aok", 32'(bus.addr_ok), 32'd0);
    resp_stall_i = 1'b0;
    issue(1'b0, 2'd2, 32'h114, 32'd0);
    issue(1'b0, 2'd2, 32'h118, 32'd0);
    idle(8);
    check("t3_pulses", 32'(n_dok - base), 32'd6);
    check("t3_last", last_rd, 32'hA0A0_0005);

    // Misaligned and illegal-size requests
    issue(1'b1, 2'd2, 32'h102, 32'h12345678);
    issue(1'b0, 2'd3, 32'h100, 32'd0);
    issue(1'b0, 2'd2, 32'h100, 32'd0);
    idle(4);
    check("t4_unchanged", last_rd, 32'hBEEFAA44);

    // Acceptance stall with request held
    stall_i = 1'b1;
    bus.req = 1'b1; bus.wr = 1'b0; bus.size = 2'd2; bus.addr = 32'h104;
    repeat (5) tick();
    stall_i = 1'b0;
    issue(1'b0, 2'd2, 32'h104, 32'd0);
    idle(4);
    check("t5_rdata", last_rd, 32'hA0A0_0000);

    // Reset with requests outstanding
    resp_stall_i = 1'b1;
    issue(1'b1, 2'd2, 32'h120, 32'hCAFEF00D);
    issue(1'b0, 2'd2, 32'h100, 32'd0);
    issue(1'b0, 2'd2, 32'h104, 32'd0);
    check("t6_pre_occ", 32'(outstanding_o), 32'd3);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("t6");
    mq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    resp_stall_i = 1'b0;
    idle(3);
    issue(1'b0, 2'd2, 32'h120, 32'd0);
    idle(4);
    check("t6_retained", last_rd, 32'hCAFEF00D);

    // Randomized traffic over a small aliased window
    for (int i = 0; i < 16; i++) issue(1'b1, 2'd2, 32'h100 + 4 * i, $urandom);
    idle(4);
    hold = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!hold) begin
        bus.req = ($urandom % 3) != 0;
        bus.wr  = $urandom % 2;
        r = $urandom % 10;
        bus.size  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        bus.addr  = ($urandom & 32'hFFFF_C000) | (32'h100 + ($urandom % 64));
        bus.wdata = $urandom;
      end
      stall_i      = ($urandom % 6) == 0;
      resp_stall_i = ($urandom % 4) == 0;
      tick();
      hold = bus.req && !last_acc;
    end
    stall_i = 1'b0;
    resp_stall_i = 1'b0;
    idle(3 * DEPTH + LATENCY + 4);
    check("drain_empty", 32'(outstanding_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
